// File: rtl/osc_pkg.sv
// Shared constants and readout state encoding for the oscilloscope capture readout path.
package osc_pkg;
   localparam int DEPTH   = 1024;
   localparam int AW      = 10;
   localparam int SRAM_AW = 18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LO,
      ST_HI,
      ST_DONE
   } rd_state_e;
endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer plus rising-edge pulse for an asynchronous strobe.
// Pulse is valid in the cycle after the second sync flop captures the rise; no backpressure.
module osc_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pls
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic hist_q, hist_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      hist_d = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign rise_pls = sync_q & ~hist_q;
endmodule

// File: rtl/osc_readout.sv
// Streams a captured ring of 16-bit SRAM words to an MCU, one byte per strobe, oldest first.
// Data_Ready rises WAIT_CYC+2 cycles after Start; the MCU paces the transfer, early strobes flag Overrun.
module osc_readout #(
   parameter int DEPTH    = osc_pkg::DEPTH,
   parameter int AW       = osc_pkg::AW,
   parameter int WAIT_CYC = 2
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        Start,
   input  logic [AW-1:0]               Start_Add,
   input  logic                        Abort,
   input  logic                        MCU_Read,
   output logic [7:0]                  MCU_Data,
   output logic                        Data_Ready,
   output logic                        Read_Done,
   output logic                        Overrun,
   output logic [osc_pkg::SRAM_AW-1:0] SRAM_Add,
   input  logic [15:0]                 SRAM_Data,
   output logic                        SRAM_OE_n,
   output logic                        SRAM_WE_n
);
   import osc_pkg::*;

   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
   localparam logic [3:0]    WAIT_LAT = 4'(WAIT_CYC - 1);
   localparam logic [3:0]    WAIT_END = 4'(WAIT_CYC);

   rd_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [3:0]    wait_q, wait_d;
   logic [15:0]   word_q, word_d;
   logic [7:0]    mcu_data_q, mcu_data_d;
   logic          data_ready_q, data_ready_d;
   logic          read_done_q, read_done_d;
   logic          overrun_q, overrun_d;
   logic          oe_n_q, oe_n_d;
   logic          rd_edge;

   osc_edge_sync u_rd_sync (
      .clk      (CLK),
      .rst      (RESET),
      .async_in (MCU_Read),
      .rise_pls (rd_edge)
   );

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      wait_d       = wait_q;
      word_d       = word_q;
      mcu_data_d   = mcu_data_q;
      data_ready_d = data_ready_q;
      read_done_d  = read_done_q;
      overrun_d    = overrun_q;
      oe_n_d       = oe_n_q;

      if (Abort) begin
         state_d      = ST_IDLE;
         wait_d       = '0;
         oe_n_d       = 1'b1;
         data_ready_d = 1'b0;
         read_done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (rd_edge) overrun_d = 1'b1;
               if (Start) begin
                  ptr_d       = Start_Add;
                  cnt_d       = '0;
                  wait_d      = '0;
                  overrun_d   = 1'b0;
                  read_done_d = 1'b0;
                  oe_n_d      = 1'b0;
                  state_d     = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (rd_edge) overrun_d = 1'b1;
               // Word is captured on the last OE-low cycle, then presented one cycle later.
               if (wait_q == WAIT_END) begin
                  wait_d       = '0;
                  mcu_data_d   = word_q[7:0];
                  data_ready_d = 1'b1;
                  state_d      = ST_LO;
               end else begin
                  wait_d = wait_q + 4'd1;
                  if (wait_q == WAIT_LAT) begin
                     word_d = SRAM_Data;
                     oe_n_d = 1'b1;
                  end
               end
            end
            ST_LO: begin
               if (rd_edge) begin
                  mcu_data_d = word_q[15:8];
                  state_d    = ST_HI;
               end
            end
            ST_HI: begin
               if (rd_edge) begin
                  data_ready_d = 1'b0;
                  if (cnt_q == CNT_LAST) begin
                     read_done_d = 1'b1;
                     state_d     = ST_DONE;
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     ptr_d   = ptr_q + 1'b1;
                     wait_d  = '0;
                     oe_n_d  = 1'b0;
                     state_d = ST_FETCH;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         wait_q       <= '0;
         word_q       <= '0;
         mcu_data_q   <= '0;
         data_ready_q <= 1'b0;
         read_done_q  <= 1'b0;
         overrun_q    <= 1'b0;
         oe_n_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         wait_q       <= wait_d;
         word_q       <= word_d;
         mcu_data_q   <= mcu_data_d;
         data_ready_q <= data_ready_d;
         read_done_q  <= read_done_d;
         overrun_q    <= overrun_d;
         oe_n_q       <= oe_n_d;
      end
   end

   assign MCU_Data   = mcu_data_q;
   assign Data_Ready = data_ready_q;
   assign Read_Done  = read_done_q;
   assign Overrun    = overrun_q;
   assign SRAM_OE_n  = oe_n_q;
   assign SRAM_WE_n  = 1'b1;
   assign SRAM_Add   = {{(SRAM_AW-AW){1'b0}}, ptr_q};
endmodule

// File: tb/tb_osc_readout.sv
// Bench for osc_readout: cycle table for fetch timing, then randomized ring readouts against a byte-queue model.
module tb_osc_readout;
   localparam int DEPTH    = 1024;
   localparam int AW       = 10;
   localparam int WAIT_CYC = 3;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          Start = 1'b0;
   logic [AW-1:0] Start_Add = '0;
   logic          Abort = 1'b0;
   logic          MCU_Read = 1'b0;
   logic [7:0]    MCU_Data;
   logic          Data_Ready, Read_Done, Overrun;
   logic [17:0]   SRAM_Add;
   logic [15:0]   SRAM_Data;
   logic          SRAM_OE_n, SRAM_WE_n;

   logic [15:0] mem [0:DEPTH-1];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_bytes[$];
   int          exp_addr[$];
   int          got_addr[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          hi_err = 0;
   int          we_err = 0;
   int          oe_low_cnt = 0;
   logic        prev_oe = 1'b1;

   typedef struct {
      logic          start;
      logic          abort;
      logic [AW-1:0] sadd;
      logic          exp_oe_n;
      logic          exp_dr;
      logic          chk_add;
      logic          chk_dat;
      logic [7:0]    exp_dat;
   } vec_t;
   vec_t tbl [9];

   always #5 CLK = ~CLK;

   assign SRAM_Data = SRAM_OE_n ? 16'hA5A5 : mem[SRAM_Add[AW-1:0]];

   osc_readout #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYC(WAIT_CYC)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .Start      (Start),
      .Start_Add  (Start_Add),
      .Abort      (Abort),
      .MCU_Read   (MCU_Read),
      .MCU_Data   (MCU_Data),
      .Data_Ready (Data_Ready),
      .Read_Done  (Read_Done),
      .Overrun    (Overrun),
      .SRAM_Add   (SRAM_Add),
      .SRAM_Data  (SRAM_Data),
      .SRAM_OE_n  (SRAM_OE_n),
      .SRAM_WE_n  (SRAM_WE_n)
   );

   // SRAM bus monitor: records the address of every new read access.
   always @(negedge CLK) begin
      if (RESET) begin
         prev_oe = 1'b1;
      end else begin
         if (SRAM_OE_n == 1'b0 && prev_oe) got_addr.push_back(int'(SRAM_Add));
         if (SRAM_OE_n == 1'b0) oe_low_cnt++;
         if (SRAM_Add[17:AW] != '0) hi_err++;
         prev_oe = SRAM_OE_n;
      end
      if (SRAM_WE_n !== 1'b1) we_err++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_dat"}, MCU_Data, 0);
      chk({p, "_dr"}, Data_Ready, 0);
      chk({p, "_done"}, Read_Done, 0);
      chk({p, "_ovr"}, Overrun, 0);
      chk({p, "_add"}, SRAM_Add, 0);
      chk({p, "_oe"}, SRAM_OE_n, 1);
      chk({p, "_we"}, SRAM_WE_n, 1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
   endtask

   // Reference: a readout from addr delivers every ring word once, oldest first, low byte then high byte.
   task automatic do_start(input int addr);
      exp_q.delete();
      exp_addr.delete();
      for (int k = 0; k < DEPTH; k++) begin
         int idx;
         idx = (addr + k) % DEPTH;
         exp_addr.push_back(idx);
         exp_q.push_back(mem[idx][7:0]);
         exp_q.push_back(mem[idx][15:8]);
      end
      got_addr.delete();
      got_bytes.delete();
      Start = 1'b1;
      Start_Add = AW'(addr);
      @(negedge CLK);
      Start = 1'b0;
   endtask

   task automatic strobe();
      MCU_Read = 1'b1;
      repeat (2) @(negedge CLK);
      MCU_Read = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic do_abort();
      Abort = 1'b1;
      @(negedge CLK);
      Abort = 1'b0;
   endtask

   task automatic consume(input int nbytes, input int inject_at, output int errs);
      errs = 0;
      for (int i = 0; i < nbytes; i++) begin
         int t;
         logic [7:0] e;
         t = 0;
         while (Data_Ready !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
         end
         if (Data_Ready !== 1'b1 || exp_q.size() == 0) begin
            errs += 1000;
            break;
         end
         e = exp_q.pop_front();
         got_bytes.push_back(MCU_Data);
         if (MCU_Data !== e) errs++;
         if (Read_Done !== 1'b0) errs++;
         if (i == inject_at) begin
            Start = 1'b1;
            Start_Add = AW'($urandom_range(0, DEPTH - 1));
            @(negedge CLK);
            Start = 1'b0;
         end
         strobe();
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
   endtask

   task automatic chk_addr(input string name, input int n);
      int m;
      m = 0;
      chk({name, "_n"}, got_addr.size(), n);
      for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++)
         if (got_addr[k] != exp_addr[k]) m++;
      chk(name, m, 0);
   endtask

   initial begin
      int errs;
      int a;

      for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i + 16'h0100);
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      chk_rst("reset");

      // Fetch timing with WAIT_CYC=3: OE low cycles 1-3, Data_Ready at cycle 5; Abort beats Start.
      tbl[0] = '{1'b1, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b0, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b0, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 1'b0, 10'h155, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{1'b0, 1'b1, 10'h155, 1'b1, 1'b1, 1'b0, 1'b1, mem[10'h155][7:0]};
      tbl[6] = '{1'b1, 1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[7] = '{1'b0, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[8] = '{1'b0, 1'b0, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("tbl%0d_oe", i), SRAM_OE_n, tbl[i].exp_oe_n);
         chk($sformatf("tbl%0d_dr", i), Data_Ready, tbl[i].exp_dr);
         chk($sformatf("tbl%0d_done", i), Read_Done, 0);
         if (tbl[i].chk_add) chk($sformatf("tbl%0d_add", i), SRAM_Add, tbl[i].sadd);
         if (tbl[i].chk_dat) chk($sformatf("tbl%0d_dat", i), MCU_Data, tbl[i].exp_dat);
         Start = tbl[i].start;
         Abort = tbl[i].abort;
         Start_Add = tbl[i].sadd;
         @(negedge CLK);
      end
      chk("tbl_ovr", Overrun, 0);

      // Full readout from index 0 with word = index + 0x0100.
      do_start(0);
      consume(2 * DEPTH, -1, errs);
      chk("seq0", errs, 0);
      chk("byte0", got_bytes.size() > 0 ? got_bytes[0] : 8'hxx, 8'h00);
      chk("byte1", got_bytes.size() > 1 ? got_bytes[1] : 8'hxx, 8'h01);
      chk("byte2", got_bytes.size() > 2 ? got_bytes[2] : 8'hxx, 8'h01);
      chk("byte3", got_bytes.size() > 3 ? got_bytes[3] : 8'hxx, 8'h01);
      repeat (5) @(negedge CLK);
      chk("done0", Read_Done, 1);
      chk("done0_dr", Data_Ready, 0);
      chk("done0_dat", MCU_Data, 8'h04);
      chk("done0_ovr", Overrun, 0);
      chk_addr("addr0", DEPTH);

      // Wrapping readout from 1020, restarted from DONE, with an ignored Start mid-readout.
      fill_random();
      do_start(1020);
      consume(2 * DEPTH, 5, errs);
      chk("seq1020", errs, 0);
      repeat (5) @(negedge CLK);
      chk("done1020", Read_Done, 1);
      chk_addr("addr1020", DEPTH);
      chk("addr1020_first", got_addr.size() > 0 ? got_addr[0] : -1, 1020);
      chk("addr1020_wrap", got_addr.size() > 4 ? got_addr[4] : -1, 0);
      strobe();
      chk("done_strobe_ovr", Overrun, 1);
      chk("done_strobe_done", Read_Done, 1);
      chk("done_strobe_dat", MCU_Data, mem[1019][15:8]);

      // Strobe during FETCH: flagged, not consumed.
      fill_random();
      a = int'($urandom_range(0, DEPTH - 1));
      do_start(a);
      chk("start_clr_ovr", Overrun, 0);
      strobe();
      chk("fetch_ovr", Overrun, 1);
      consume(8, -1, errs);
      chk("seq_ovr", errs, 0);
      chk_addr("addr_ovr", 5);
      do_abort();
      chk("abort1_dr", Data_Ready, 0);
      chk("abort1_oe", SRAM_OE_n, 1);
      chk("abort1_done", Read_Done, 0);

      // Abort in HI after 500 words, then restart at 7.
      a = int'($urandom_range(0, DEPTH - 1));
      do_start(a);
      chk("restart_ovr", Overrun, 0);
      consume(1001, -1, errs);
      chk("seq500", errs, 0);
      chk("hi_dr", Data_Ready, 1);
      chk("hi_dat", MCU_Data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
      chk_addr("addr500", 501);
      do_abort();
      chk("abort2_dr", Data_Ready, 0);
      chk("abort2_oe", SRAM_OE_n, 1);
      chk("abort2_done", Read_Done, 0);
      do_start(7);
      consume(4, -1, errs);
      chk("seq7", errs, 0);
      chk("addr7_first", got_addr.size() > 0 ? got_addr[0] : -1, 7);
      chk_addr("addr7", 3);

      // Reset during FETCH: immediate reset values, then no SRAM access and strobes only flag Overrun.
      do_abort();
      do_start(int'($urandom_range(0, DEPTH - 1)));
      @(negedge CLK);
      chk("pre_rst_oe", SRAM_OE_n, 0);
      RESET = 1'b1;
      #1;
      chk_rst("midrst");
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      oe_low_cnt = 0;
      @(negedge CLK);
      strobe();
      strobe();
      repeat (3) @(negedge CLK);
      chk("post_rst_ovr", Overrun, 1);
      chk("post_rst_dr", Data_Ready, 0);
      chk("post_rst_done", Read_Done, 0);
      chk("post_rst_dat", MCU_Data, 0);
      chk("post_rst_access", oe_low_cnt, 0);
      chk("we_n_held", we_err, 0);
      chk("add_upper_zero", hi_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
